// File: rtl/eth_phy_rx_lock_monitor.sv
// 10GBASE-R receive block-lock and BER monitor for the 64b/66b PCS.
// Drives bitslip and SerDes reset requests; reports lock, high BER, status and an error count.
module eth_phy_rx_lock_monitor #(
    parameter int HDR_WIDTH      = 2,
    parameter int LOCK_CNT       = 64,
    parameter int UNLOCK_WINDOW  = 64,
    parameter int UNLOCK_INVALID = 16,
    parameter int SLIP_WAIT      = 8,
    parameter int SLIP_LIMIT     = 66,
    parameter int BER_WINDOW     = 19531,
    parameter int BER_THRESH     = 16,
    parameter int ERR_CNT_WIDTH  = 7
) (
    input  logic                     rx_clk,
    input  logic                     rx_rst,
    input  logic [HDR_WIDTH-1:0]     serdes_rx_hdr,
    input  logic                     serdes_rx_hdr_valid,
    input  logic                     rx_error_count_clr,
    output logic                     serdes_rx_bitslip,
    output logic                     serdes_rx_reset_req,
    output logic                     rx_block_lock,
    output logic                     rx_high_ber,
    output logic                     rx_status,
    output logic [ERR_CNT_WIDTH-1:0] rx_error_count
);

    localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(UNLOCK_WINDOW + 1);
    localparam int BAD_W   = $clog2(UNLOCK_INVALID + 1);
    localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
    localparam int SLIPC_W = $clog2(SLIP_LIMIT + 1);
    localparam int TMR_W   = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
    localparam int BER_W   = $clog2(BER_THRESH + 1);

    localparam logic [GOOD_W-1:0]        LOCK_CNT_C   = GOOD_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]         UNLOCK_WIN_C = WIN_W'(UNLOCK_WINDOW);
    localparam logic [BAD_W-1:0]         UNLOCK_INV_C = BAD_W'(UNLOCK_INVALID);
    localparam logic [WAIT_W-1:0]        WAIT_LAST_C  = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [SLIPC_W-1:0]       SLIP_LIMIT_C = SLIPC_W'(SLIP_LIMIT);
    localparam logic [TMR_W-1:0]         TMR_LAST_C   = TMR_W'(BER_WINDOW - 1);
    localparam logic [BER_W-1:0]         BER_THRESH_C = BER_W'(BER_THRESH);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX_C    = '1;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SLIP   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [GOOD_W-1:0]        good_cnt_q, good_cnt_d;
    logic [WIN_W-1:0]         win_cnt_q, win_cnt_d;
    logic [BAD_W-1:0]         bad_cnt_q, bad_cnt_d;
    logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [SLIPC_W-1:0]       slip_cnt_q, slip_cnt_d;
    logic [TMR_W-1:0]         ber_tmr_q, ber_tmr_d;
    logic [BER_W-1:0]         ber_cnt_q, ber_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     bitslip_q, bitslip_d;
    logic                     reset_req_q, reset_req_d;
    logic                     block_lock_q, block_lock_d;
    logic                     high_ber_q, high_ber_d;
    logic                     status_q, status_d;

    logic                     hdr_good;
    logic                     hdr_bad;
    logic [GOOD_W-1:0]        good_next;
    logic [WIN_W-1:0]         win_next;
    logic [BAD_W-1:0]         bad_next;
    logic [SLIPC_W-1:0]       slip_next;
    logic                     tmr_wrap;
    logic [BER_W-1:0]         ber_sum;
    logic [ERR_CNT_WIDTH-1:0] err_base;

    // 01 and 10 are the only legal sync headers; unqualified cycles are neither good nor bad.
    assign hdr_good  = serdes_rx_hdr_valid &  (serdes_rx_hdr[1] ^ serdes_rx_hdr[0]);
    assign hdr_bad   = serdes_rx_hdr_valid & ~(serdes_rx_hdr[1] ^ serdes_rx_hdr[0]);
    assign good_next = good_cnt_q + 1'b1;
    assign win_next  = win_cnt_q + 1'b1;
    assign bad_next  = bad_cnt_q + BAD_W'(hdr_bad);
    assign slip_next = slip_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        win_cnt_d   = win_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        bitslip_d   = 1'b0;
        reset_req_d = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (hdr_good) begin
                    if (good_next == LOCK_CNT_C) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                        slip_cnt_d = '0;
                        win_cnt_d  = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_next;
                    end
                end else if (hdr_bad) begin
                    state_d    = ST_SLIP;
                    good_cnt_d = '0;
                    wait_cnt_d = '0;
                    // Too many slips without lock: ask for a SerDes reset instead.
                    if (slip_next == SLIP_LIMIT_C) begin
                        reset_req_d = 1'b1;
                        slip_cnt_d  = '0;
                    end else begin
                        bitslip_d   = 1'b1;
                        slip_cnt_d  = slip_next;
                    end
                end
            end
            ST_SLIP: begin
                if (wait_cnt_q == WAIT_LAST_C) begin
                    state_d    = ST_HUNT;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (serdes_rx_hdr_valid) begin
                    // Unlock takes priority over a window boundary on the same block.
                    if (bad_next == UNLOCK_INV_C) begin
                        state_d    = ST_SLIP;
                        bitslip_d  = 1'b1;
                        slip_cnt_d = SLIPC_W'(1);
                        wait_cnt_d = '0;
                        win_cnt_d  = '0;
                        bad_cnt_d  = '0;
                    end else if (win_next == UNLOCK_WIN_C) begin
                        win_cnt_d  = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        win_cnt_d  = win_next;
                        bad_cnt_d  = bad_next;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // BER window: saturating count of bad headers seen while locked, judged at each timer wrap.
    always_comb begin
        tmr_wrap   = (ber_tmr_q == TMR_LAST_C);
        ber_tmr_d  = tmr_wrap ? '0 : ber_tmr_q + 1'b1;
        ber_sum    = ber_cnt_q;
        if (hdr_bad && block_lock_q && (ber_cnt_q != BER_THRESH_C)) begin
            ber_sum = ber_cnt_q + 1'b1;
        end
        high_ber_d = high_ber_q;
        ber_cnt_d  = ber_sum;
        if (ber_sum == BER_THRESH_C) begin
            high_ber_d = 1'b1;
        end
        if (tmr_wrap) begin
            ber_cnt_d = '0;
            if (ber_sum != BER_THRESH_C) begin
                high_ber_d = 1'b0;
            end
        end
    end

    always_comb begin
        err_base  = rx_error_count_clr ? '0 : err_cnt_q;
        err_cnt_d = err_base;
        if (hdr_bad && (err_base != ERR_MAX_C)) begin
            err_cnt_d = err_base + 1'b1;
        end
        block_lock_d = (state_d == ST_LOCKED);
        status_d     = block_lock_d & ~high_ber_d;
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q      <= ST_HUNT;
            good_cnt_q   <= '0;
            win_cnt_q    <= '0;
            bad_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            slip_cnt_q   <= '0;
            ber_tmr_q    <= '0;
            ber_cnt_q    <= '0;
            err_cnt_q    <= '0;
            bitslip_q    <= 1'b0;
            reset_req_q  <= 1'b0;
            block_lock_q <= 1'b0;
            high_ber_q   <= 1'b0;
            status_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            win_cnt_q    <= win_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            ber_tmr_q    <= ber_tmr_d;
            ber_cnt_q    <= ber_cnt_d;
            err_cnt_q    <= err_cnt_d;
            bitslip_q    <= bitslip_d;
            reset_req_q  <= reset_req_d;
            block_lock_q <= block_lock_d;
            high_ber_q   <= high_ber_d;
            status_q     <= status_d;
        end
    end

    assign serdes_rx_bitslip   = bitslip_q;
    assign serdes_rx_reset_req = reset_req_q;
    assign rx_block_lock       = block_lock_q;
    assign rx_high_ber         = high_ber_q;
    assign rx_status           = status_q;
    assign rx_error_count      = err_cnt_q;

endmodule

// File: tb/tb_eth_phy_rx_lock_monitor.sv
// Bench for eth_phy_rx_lock_monitor: directed scenarios plus randomized traffic
// checked every cycle against a cycle-numbered behavioural model.
module tb_eth_phy_rx_lock_monitor;

    localparam int LOCK_CNT       = 64;
    localparam int UNLOCK_WINDOW  = 64;
    localparam int UNLOCK_INVALID = 16;
    localparam int SLIP_WAIT      = 8;
    localparam int SLIP_LIMIT     = 4;
    localparam int BER_WINDOW     = 200;
    localparam int BER_THRESH     = 4;
    localparam int ERR_CNT_WIDTH  = 3;
    localparam int ERR_MAX        = (1 << ERR_CNT_WIDTH) - 1;

    logic                     rx_clk = 1'b0;
    logic                     rx_rst = 1'b1;
    logic [1:0]               serdes_rx_hdr = 2'b00;
    logic                     serdes_rx_hdr_valid = 1'b0;
    logic                     rx_error_count_clr = 1'b0;
    logic                     serdes_rx_bitslip;
    logic                     serdes_rx_reset_req;
    logic                     rx_block_lock;
    logic                     rx_high_ber;
    logic                     rx_status;
    logic [ERR_CNT_WIDTH-1:0] rx_error_count;

    int checks = 0;
    int passed = 0;

    // Model state: absolute edge numbers since reset release rather than wait counters.
    int  m_edge;
    int  m_hunt_from;
    bit  m_lock;
    int  m_good;
    int  m_slips;
    int  m_win;
    int  m_bad;
    int  m_ber;
    bit  m_high;
    int  m_err;
    bit  m_slip;
    bit  m_rreq;

    eth_phy_rx_lock_monitor #(
        .HDR_WIDTH      (2),
        .LOCK_CNT       (LOCK_CNT),
        .UNLOCK_WINDOW  (UNLOCK_WINDOW),
        .UNLOCK_INVALID (UNLOCK_INVALID),
        .SLIP_WAIT      (SLIP_WAIT),
        .SLIP_LIMIT     (SLIP_LIMIT),
        .BER_WINDOW     (BER_WINDOW),
        .BER_THRESH     (BER_THRESH),
        .ERR_CNT_WIDTH  (ERR_CNT_WIDTH)
    ) dut (
        .rx_clk              (rx_clk),
        .rx_rst              (rx_rst),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
        .rx_error_count_clr  (rx_error_count_clr),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .rx_block_lock       (rx_block_lock),
        .rx_high_ber         (rx_high_ber),
        .rx_status           (rx_status),
        .rx_error_count      (rx_error_count)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [1:0] goodHdr();
        logic [1:0] h;
        h = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        return h;
    endfunction

    function automatic logic [1:0] badHdr();
        logic [1:0] h;
        h = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        return h;
    endfunction

    task automatic modelReset();
        m_edge = 0; m_hunt_from = 0; m_lock = 0; m_good = 0; m_slips = 0;
        m_win = 0; m_bad = 0; m_ber = 0; m_high = 0; m_err = 0; m_slip = 0; m_rreq = 0;
    endtask

    task automatic modelStep(input bit hv, input logic [1:0] hdr, input bit clr);
        bit is_bad;
        bit is_good;
        bit was_locked;
        is_bad     = hv && (hdr == 2'b00 || hdr == 2'b11);
        is_good    = hv && !is_bad;
        was_locked = m_lock;
        m_slip = 0;
        m_rreq = 0;
        if (clr) m_err = 0;
        if (is_bad && m_err < ERR_MAX) m_err++;
        if (m_lock) begin
            if (hv) begin
                m_win++;
                if (is_bad) m_bad++;
                if (m_bad == UNLOCK_INVALID) begin
                    m_lock = 0; m_slip = 1; m_slips = 1;
                    m_hunt_from = m_edge + SLIP_WAIT + 1;
                    m_win = 0; m_bad = 0;
                end else if (m_win == UNLOCK_WINDOW) begin
                    m_win = 0; m_bad = 0;
                end
            end
        end else if (m_edge >= m_hunt_from) begin
            if (is_good) begin
                m_good++;
                if (m_good == LOCK_CNT) begin
                    m_lock = 1; m_good = 0; m_slips = 0; m_win = 0; m_bad = 0;
                end
            end else if (is_bad) begin
                m_good = 0;
                m_slips++;
                if (m_slips == SLIP_LIMIT) begin
                    m_rreq = 1; m_slips = 0;
                end else begin
                    m_slip = 1;
                end
                m_hunt_from = m_edge + SLIP_WAIT + 1;
            end
        end
        if (was_locked && is_bad && m_ber < BER_THRESH) m_ber++;
        if (m_ber == BER_THRESH) m_high = 1;
        if ((m_edge % BER_WINDOW) == BER_WINDOW - 1) begin
            if (m_ber < BER_THRESH) m_high = 0;
            m_ber = 0;
        end
        m_edge++;
    endtask

    task automatic compareAll();
        checkOutput("lock",      32'(rx_block_lock),       32'(m_lock));
        checkOutput("high_ber",  32'(rx_high_ber),         32'(m_high));
        checkOutput("status",    32'(rx_status),           32'(m_lock && !m_high));
        checkOutput("bitslip",   32'(serdes_rx_bitslip),   32'(m_slip));
        checkOutput("reset_req", 32'(serdes_rx_reset_req), 32'(m_rreq));
        checkOutput("err_cnt",   32'(rx_error_count),      32'(m_err));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_lock"},  32'(rx_block_lock), 0);
        checkOutput({tag, "_ber"},   32'(rx_high_ber), 0);
        checkOutput({tag, "_stat"},  32'(rx_status), 0);
        checkOutput({tag, "_slip"},  32'(serdes_rx_bitslip), 0);
        checkOutput({tag, "_rreq"},  32'(serdes_rx_reset_req), 0);
        checkOutput({tag, "_err"},   32'(rx_error_count), 0);
    endtask

    // Drives one cycle of inputs, advances the model over the same edge and compares #1 later.
    task automatic applyStimulus(input bit hv, input logic [1:0] hdr, input bit clr);
        serdes_rx_hdr_valid = hv;
        serdes_rx_hdr       = hdr;
        rx_error_count_clr  = clr;
        @(posedge rx_clk);
        modelStep(hv, hdr, clr);
        #1;
        compareAll();
    endtask

    task automatic doReset();
        rx_rst = 1'b1;
        serdes_rx_hdr_valid = 1'b0;
        serdes_rx_hdr = 2'b00;
        rx_error_count_clr = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        checkAllZero("reset");
        @(negedge rx_clk);
        rx_rst = 1'b0;
        modelReset();
    endtask

    task automatic lockUp();
        for (int i = 0; i < LOCK_CNT; i++) applyStimulus(1'b1, goodHdr(), 1'b0);
    endtask

    initial begin
        int slips_before;
        int rreq_seen;
        bit saw_slip;
        bit both;
        int rates[5] = '{0, 2, 10, 40, 100};

        // Lock acquisition
        doReset();
        saw_slip = 0;
        for (int i = 0; i < LOCK_CNT; i++) begin
            applyStimulus(1'b1, goodHdr(), 1'b0);
            if (i == LOCK_CNT - 2) checkOutput("lock_early", 32'(rx_block_lock), 0);
            saw_slip |= serdes_rx_bitslip;
        end
        checkOutput("lock_acq", 32'(rx_block_lock), 1);
        checkOutput("lock_status", 32'(rx_status), 1);
        checkOutput("lock_noslip", 32'(saw_slip), 0);

        // High BER then a clean window
        for (int i = 0; i < BER_THRESH; i++) applyStimulus(1'b1, badHdr(), 1'b0);
        checkOutput("ber_high", 32'(rx_high_ber), 1);
        checkOutput("ber_status", 32'(rx_status), 0);
        checkOutput("ber_still_locked", 32'(rx_block_lock), 1);
        for (int i = 0; i < 2 * BER_WINDOW; i++) applyStimulus(1'b1, goodHdr(), 1'b0);
        checkOutput("ber_clear", 32'(rx_high_ber), 0);
        checkOutput("ber_status_back", 32'(rx_status), 1);

        // Error counter saturation and clear-with-increment
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, badHdr(), 1'b0);
        checkOutput("err_sat", 32'(rx_error_count), ERR_MAX);
        applyStimulus(1'b1, badHdr(), 1'b1);
        checkOutput("err_clr_inc", 32'(rx_error_count), 1);

        // Unlock after UNLOCK_INVALID bad headers in one window
        doReset();
        lockUp();
        for (int i = 0; i < UNLOCK_INVALID; i++) begin
            applyStimulus(1'b1, badHdr(), 1'b0);
            if (i == UNLOCK_INVALID - 2) checkOutput("unlock_early", 32'(rx_block_lock), 1);
        end
        checkOutput("unlock", 32'(rx_block_lock), 0);
        checkOutput("unlock_slip", 32'(serdes_rx_bitslip), 1);

        // One short of the unlock threshold per window keeps lock
        doReset();
        lockUp();
        for (int w = 0; w < 5; w++)
            for (int j = 0; j < UNLOCK_WINDOW; j++)
                applyStimulus(1'b1, ((j % 4) == 0 && j < 4 * (UNLOCK_INVALID - 1)) ? badHdr() : goodHdr(), 1'b0);
        checkOutput("hold_lock", 32'(rx_block_lock), 1);

        // Slip during hunt
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, goodHdr(), 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("hunt_slip", 32'(serdes_rx_bitslip), 1);
        for (int i = 0; i < SLIP_WAIT + LOCK_CNT - 1; i++) applyStimulus(1'b1, goodHdr(), 1'b0);
        checkOutput("hunt_relock_early", 32'(rx_block_lock), 0);
        applyStimulus(1'b1, goodHdr(), 1'b0);
        checkOutput("hunt_relock", 32'(rx_block_lock), 1);

        // Slip exhaustion
        doReset();
        slips_before = 0; rreq_seen = 0; both = 0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 2'b11, 1'b0);
            if (serdes_rx_bitslip && serdes_rx_reset_req) both = 1;
            if (serdes_rx_reset_req) rreq_seen++;
            if (serdes_rx_bitslip && rreq_seen == 0) slips_before++;
        end
        checkOutput("exhaust_slips", 32'(slips_before), SLIP_LIMIT - 1);
        checkOutput("exhaust_rreq", 32'(rreq_seen), 1);
        checkOutput("exhaust_overlap", 32'(both), 0);

        // Randomized traffic with a mid-run asynchronous reset
        doReset();
        for (int s = 0; s < 12; s++) begin
            int rate;
            rate = rates[$urandom_range(0, 4)];
            if (s == 6) begin
                #2 rx_rst = 1'b1;
                #1 checkAllZero("async_rst");
                @(posedge rx_clk);
                @(negedge rx_clk);
                rx_rst = 1'b0;
                modelReset();
            end
            for (int i = 0; i < 250; i++) begin
                bit hv;
                bit bad;
                bit clr;
                hv  = ($urandom_range(0, 99) < 85);
                bad = ($urandom_range(0, 99) < rate);
                clr = ($urandom_range(0, 49) == 0);
                applyStimulus(hv, bad ? badHdr() : goodHdr(), clr);
            end
        end

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
